// File: rtl/sargantana_icache_mshr.sv
// Miss-status holding registers for the icache ifill path: in-order issue, out-of-order fills.
// Define SARGANTANA_ICACHE_MSHR_COALESCE_EN to merge same-line misses; otherwise they stall.
module sargantana_icache_mshr #(
  parameter int N_ENTRIES = 4,
  parameter int LINE_W    = 34,
  parameter int WAY_W     = 2,
  localparam int ID_W     = $clog2(N_ENTRIES)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              alloc_valid_i,
  output logic              alloc_ready_o,
  input  logic [LINE_W-1:0] alloc_paddr_i,
  input  logic [WAY_W-1:0]  alloc_way_i,
  output logic [ID_W-1:0]   alloc_id_o,
  output logic              alloc_merged_o,
  output logic              req_valid_o,
  input  logic              req_ready_i,
  output logic [LINE_W-1:0] req_paddr_o,
  output logic [WAY_W-1:0]  req_way_o,
  output logic [ID_W-1:0]   req_id_o,
  input  logic              resp_valid_i,
  input  logic [ID_W-1:0]   resp_id_i,
  input  logic              inv_valid_i,
  input  logic [LINE_W-1:0] inv_paddr_i,
  output logic              fill_valid_o,
  output logic [ID_W-1:0]   fill_id_o,
  output logic [LINE_W-1:0] fill_paddr_o,
  output logic [WAY_W-1:0]  fill_way_o,
  output logic              fill_install_o,
  output logic              full_o,
  output logic              busy_o,
  output logic              err_o
);

  typedef enum logic [1:0] {FREE = 2'd0, WAIT_ISSUE = 2'd1, WAIT_RESP = 2'd2} state_t;

  state_t              state      [N_ENTRIES];
  logic [N_ENTRIES-1:0] killed;
  logic [N_ENTRIES-1:0] no_install;
  logic [LINE_W-1:0]   paddr      [N_ENTRIES];
  logic [WAY_W-1:0]    way        [N_ENTRIES];

  logic [ID_W-1:0]     fifo       [N_ENTRIES];
  logic [ID_W-1:0]     rd_ptr;
  logic [ID_W-1:0]     wr_ptr;
  logic [ID_W:0]       count;

  logic                 resp_hit;
  logic [N_ENTRIES-1:0] freeing;
  logic [N_ENTRIES-1:0] inv_hit;
  logic [N_ENTRIES-1:0] line_hit;
  logic                 free_found;
  logic [ID_W-1:0]      free_idx;
  logic                 match_found;
  logic [ID_W-1:0]      match_idx;
  logic                 busy_any;
  logic                 merge_hit;
  logic                 conflict;
  logic                 alloc_fire;
  logic                 alloc_new;
  logic                 req_fire;
  logic [ID_W-1:0]      head;

  // Lowest-index search: the loop runs downward so the smallest index wins.
  always_comb begin
    resp_hit    = resp_valid_i && (state[resp_id_i] == WAIT_RESP);
    freeing     = '0;
    inv_hit     = '0;
    line_hit    = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    match_found = 1'b0;
    match_idx   = '0;
    busy_any    = 1'b0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      freeing[i]  = resp_hit && (resp_id_i == ID_W'(i));
      inv_hit[i]  = inv_valid_i && (state[i] != FREE) && (paddr[i] == inv_paddr_i);
      line_hit[i] = (state[i] != FREE) && !killed[i] && !no_install[i] && !freeing[i] &&
                    !inv_hit[i] && (paddr[i] == alloc_paddr_i);
      if (state[i] == FREE) begin
        free_found = 1'b1;
        free_idx   = ID_W'(i);
      end else begin
        busy_any = 1'b1;
      end
      if (line_hit[i]) begin
        match_found = 1'b1;
        match_idx   = ID_W'(i);
      end
    end
  end

`ifdef SARGANTANA_ICACHE_MSHR_COALESCE_EN
  assign merge_hit = match_found;
  assign conflict  = 1'b0;
`else
  assign merge_hit = 1'b0;
  assign conflict  = match_found;
`endif

  assign alloc_ready_o  = !rst_i && !flush_i && (merge_hit || (free_found && !conflict));
  assign alloc_fire     = alloc_valid_i && alloc_ready_o;
  assign alloc_new      = alloc_fire && !merge_hit;
  assign alloc_id_o     = alloc_ready_o ? (merge_hit ? match_idx : free_idx) : '0;
  assign alloc_merged_o = alloc_ready_o && merge_hit;

  assign head        = fifo[rd_ptr];
  assign req_valid_o = !rst_i && (count != '0);
  assign req_fire    = req_valid_o && req_ready_i;
  assign req_id_o    = req_valid_o ? head : '0;
  assign req_paddr_o = req_valid_o ? paddr[head] : '0;
  assign req_way_o   = req_valid_o ? way[head] : '0;

  assign full_o = !free_found;
  assign busy_o = busy_any;

  // Entry state machine: a response beats everything, then issue, then flush, then allocation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        state[i]      <= FREE;
        killed[i]     <= 1'b0;
        no_install[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        if (freeing[i]) begin
          state[i]      <= FREE;
          killed[i]     <= 1'b0;
          no_install[i] <= 1'b0;
        end else if (req_fire && (head == ID_W'(i))) begin
          state[i] <= WAIT_RESP;
          if (flush_i) killed[i] <= 1'b1;
        end else if (flush_i && (state[i] == WAIT_ISSUE)) begin
          state[i] <= FREE;
        end else if (flush_i && (state[i] == WAIT_RESP)) begin
          killed[i] <= 1'b1;
        end else if (alloc_new && (free_idx == ID_W'(i))) begin
          state[i]      <= WAIT_ISSUE;
          killed[i]     <= 1'b0;
          no_install[i] <= 1'b0;
        end
        if (inv_hit[i] && !freeing[i]) no_install[i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (alloc_new) begin
      paddr[free_idx] <= alloc_paddr_i;
      way[free_idx]   <= alloc_way_i;
      fifo[wr_ptr]    <= free_idx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (req_fire)  rd_ptr <= rd_ptr + ID_W'(1);
      if (alloc_new) wr_ptr <= wr_ptr + ID_W'(1);
      count <= count + (ID_W+1)'(alloc_new) - (ID_W+1)'(req_fire);
    end
  end

  // p1: fill-complete stage, one cycle after the response
  logic              fill_vld_p1;
  logic [ID_W-1:0]   fill_id_p1;
  logic [LINE_W-1:0] fill_paddr_p1;
  logic [WAY_W-1:0]  fill_way_p1;
  logic              fill_install_p1;
  logic              err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fill_vld_p1     <= 1'b0;
      fill_id_p1      <= '0;
      fill_paddr_p1   <= '0;
      fill_way_p1     <= '0;
      fill_install_p1 <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      fill_vld_p1 <= resp_hit;
      if (resp_hit) begin
        fill_id_p1      <= resp_id_i;
        fill_paddr_p1   <= paddr[resp_id_i];
        fill_way_p1     <= way[resp_id_i];
        fill_install_p1 <= !killed[resp_id_i] && !no_install[resp_id_i] &&
                           !flush_i && !inv_hit[resp_id_i];
      end
      if (resp_valid_i && !resp_hit) err_q <= 1'b1;
    end
  end

  assign fill_valid_o   = fill_vld_p1;
  assign fill_id_o      = fill_id_p1;
  assign fill_paddr_o   = fill_paddr_p1;
  assign fill_way_o     = fill_way_p1;
  assign fill_install_o = fill_install_p1;
  assign err_o          = err_q;

endmodule

// File: tb/tb_sargantana_icache_mshr.sv
// Directed, table-driven bench for sargantana_icache_mshr (default and coalescing builds).
module tb_sargantana_icache_mshr;
  localparam int N_ENTRIES = 4;
  localparam int LINE_W    = 34;
  localparam int WAY_W     = 2;
  localparam int ID_W      = $clog2(N_ENTRIES);
  localparam int NV        = 43;

  typedef struct packed {
    logic rst; logic flush; logic av;
    logic [LINE_W-1:0] apa; logic [WAY_W-1:0] aw;
    logic rr; logic rsv; logic [ID_W-1:0] rsid;
    logic iv; logic [LINE_W-1:0] ipa;
    logic ar; logic am; logic [ID_W-1:0] aid;
    logic rv; logic [ID_W-1:0] rid; logic [LINE_W-1:0] rpa;
    logic fv; logic [ID_W-1:0] fid; logic [LINE_W-1:0] fpa; logic [WAY_W-1:0] fw; logic fin;
    logic full; logic busy; logic err;
  } vec_t;

  logic              clk_i = 1'b0;
  logic              rst_i, flush_i, alloc_valid_i, req_ready_i, resp_valid_i, inv_valid_i;
  logic [LINE_W-1:0] alloc_paddr_i, inv_paddr_i;
  logic [WAY_W-1:0]  alloc_way_i;
  logic [ID_W-1:0]   resp_id_i;
  logic              alloc_ready_o, alloc_merged_o, req_valid_o, fill_valid_o, fill_install_o;
  logic              full_o, busy_o, err_o;
  logic [ID_W-1:0]   alloc_id_o, req_id_o, fill_id_o;
  logic [LINE_W-1:0] req_paddr_o, fill_paddr_o;
  logic [WAY_W-1:0]  req_way_o, fill_way_o;

  int checks = 0;
  int errors = 0;
  vec_t vecs [NV];
  vec_t h;

  sargantana_icache_mshr #(.N_ENTRIES(N_ENTRIES), .LINE_W(LINE_W), .WAY_W(WAY_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o), .alloc_paddr_i(alloc_paddr_i),
    .alloc_way_i(alloc_way_i), .alloc_id_o(alloc_id_o), .alloc_merged_o(alloc_merged_o),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_paddr_o(req_paddr_o),
    .req_way_o(req_way_o), .req_id_o(req_id_o),
    .resp_valid_i(resp_valid_i), .resp_id_i(resp_id_i),
    .inv_valid_i(inv_valid_i), .inv_paddr_i(inv_paddr_i),
    .fill_valid_o(fill_valid_o), .fill_id_o(fill_id_o), .fill_paddr_o(fill_paddr_o),
    .fill_way_o(fill_way_o), .fill_install_o(fill_install_o),
    .full_o(full_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic apply(input vec_t v);
    rst_i = v.rst; flush_i = v.flush; alloc_valid_i = v.av; alloc_paddr_i = v.apa;
    alloc_way_i = v.aw; req_ready_i = v.rr; resp_valid_i = v.rsv; resp_id_i = v.rsid;
    inv_valid_i = v.iv; inv_paddr_i = v.ipa;
  endtask

  task automatic check_vec(input int idx, input vec_t v);
    logic ok;
    ok = (alloc_ready_o == v.ar) && (alloc_merged_o == v.am) &&
         (!(v.av && v.ar) || (alloc_id_o == v.aid)) &&
         (req_valid_o == v.rv) && (!v.rv || (req_id_o == v.rid && req_paddr_o == v.rpa)) &&
         (fill_valid_o == v.fv) &&
         (!v.fv || (fill_id_o == v.fid && fill_paddr_o == v.fpa && fill_way_o == v.fw &&
                    fill_install_o == v.fin)) &&
         (full_o == v.full) && (busy_o == v.busy) && (err_o == v.err);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL vec%0d: got ar=%b am=%b aid=%0d rv=%b rid=%0d rpa=%h fv=%b fid=%0d fpa=%h fw=%0d fin=%b full=%b busy=%b err=%b; expected ar=%b am=%b aid=%0d rv=%b rid=%0d rpa=%h fv=%b fid=%0d fpa=%h fw=%0d fin=%b full=%b busy=%b err=%b",
               idx, alloc_ready_o, alloc_merged_o, alloc_id_o, req_valid_o, req_id_o, req_paddr_o,
               fill_valid_o, fill_id_o, fill_paddr_o, fill_way_o, fill_install_o, full_o, busy_o, err_o,
               v.ar, v.am, v.aid, v.rv, v.rid, v.rpa, v.fv, v.fid, v.fpa, v.fw, v.fin, v.full, v.busy, v.err);
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // Single miss, then four misses with out-of-order responses
    vecs[0]  = '{rst:1, default:0};
    vecs[1]  = '{av:1, apa:'h100, aw:2, ar:1, aid:0, default:0};
    vecs[2]  = '{rr:1, ar:1, rv:1, rid:0, rpa:'h100, busy:1, default:0};
    vecs[3]  = '{rsv:1, rsid:0, ar:1, busy:1, default:0};
    vecs[4]  = '{ar:1, fv:1, fid:0, fpa:'h100, fw:2, fin:1, default:0};
    vecs[5]  = '{av:1, apa:'h10, aw:1, ar:1, aid:0, default:0};
    vecs[6]  = '{av:1, apa:'h11, aw:1, ar:1, aid:1, rv:1, rid:0, rpa:'h10, busy:1, default:0};
    vecs[7]  = '{av:1, apa:'h12, aw:1, ar:1, aid:2, rv:1, rid:0, rpa:'h10, busy:1, default:0};
    vecs[8]  = '{av:1, apa:'h13, aw:1, ar:1, aid:3, rv:1, rid:0, rpa:'h10, busy:1, default:0};
    vecs[9]  = '{av:1, apa:'h14, aw:1, rv:1, rid:0, rpa:'h10, full:1, busy:1, default:0};
    vecs[10] = '{av:1, apa:'h14, aw:1, rr:1, rv:1, rid:0, rpa:'h10, full:1, busy:1, default:0};
    vecs[11] = '{rr:1, rv:1, rid:1, rpa:'h11, full:1, busy:1, default:0};
    vecs[12] = '{rr:1, rv:1, rid:2, rpa:'h12, full:1, busy:1, default:0};
    vecs[13] = '{rr:1, rv:1, rid:3, rpa:'h13, full:1, busy:1, default:0};
    vecs[14] = '{full:1, busy:1, default:0};
    vecs[15] = '{rsv:1, rsid:3, full:1, busy:1, default:0};
    vecs[16] = '{rsv:1, rsid:1, ar:1, fv:1, fid:3, fpa:'h13, fw:1, fin:1, busy:1, default:0};
    vecs[17] = '{rsv:1, rsid:0, ar:1, fv:1, fid:1, fpa:'h11, fw:1, fin:1, busy:1, default:0};
    vecs[18] = '{rsv:1, rsid:2, ar:1, fv:1, fid:0, fpa:'h10, fw:1, fin:1, busy:1, default:0};
    vecs[19] = '{ar:1, fv:1, fid:2, fpa:'h12, fw:1, fin:1, default:0};
    vecs[20] = '{av:1, apa:'h20, ar:1, aid:0, default:0};
`ifdef SARGANTANA_ICACHE_MSHR_COALESCE_EN
    vecs[21] = '{av:1, apa:'h20, rr:1, ar:1, am:1, aid:0, rv:1, rid:0, rpa:'h20, busy:1, default:0};
    vecs[22] = '{ar:1, busy:1, default:0};
    vecs[23] = '{rsv:1, rsid:0, ar:1, busy:1, default:0};
    vecs[24] = '{ar:1, fv:1, fid:0, fpa:'h20, fin:1, default:0};
    vecs[25] = '{ar:1, default:0};
    vecs[26] = '{ar:1, default:0};
    vecs[27] = '{ar:1, default:0};
`else
    vecs[21] = '{av:1, apa:'h20, rr:1, rv:1, rid:0, rpa:'h20, busy:1, default:0};
    vecs[22] = '{av:1, apa:'h20, busy:1, default:0};
    vecs[23] = '{av:1, apa:'h20, rsv:1, rsid:0, ar:1, aid:1, busy:1, default:0};
    vecs[24] = '{ar:1, fv:1, fid:0, fpa:'h20, fin:1, rv:1, rid:1, rpa:'h20, busy:1, default:0};
    vecs[25] = '{rr:1, ar:1, rv:1, rid:1, rpa:'h20, busy:1, default:0};
    vecs[26] = '{rsv:1, rsid:1, ar:1, busy:1, default:0};
    vecs[27] = '{ar:1, fv:1, fid:1, fpa:'h20, fin:1, default:0};
`endif
    // Flush with two entries waiting for data and one waiting to issue
    vecs[28] = '{av:1, apa:'h40, aw:0, ar:1, aid:0, default:0};
    vecs[29] = '{av:1, apa:'h41, aw:1, rr:1, ar:1, aid:1, rv:1, rid:0, rpa:'h40, busy:1, default:0};
    vecs[30] = '{av:1, apa:'h42, aw:2, rr:1, ar:1, aid:2, rv:1, rid:1, rpa:'h41, busy:1, default:0};
    vecs[31] = '{flush:1, rv:1, rid:2, rpa:'h42, busy:1, default:0};
    vecs[32] = '{ar:1, busy:1, default:0};
    vecs[33] = '{rsv:1, rsid:1, ar:1, busy:1, default:0};
    vecs[34] = '{rsv:1, rsid:0, ar:1, fv:1, fid:1, fpa:'h41, fw:1, fin:0, busy:1, default:0};
    vecs[35] = '{ar:1, fv:1, fid:0, fpa:'h40, fw:0, fin:0, default:0};
    // Invalidation of an in-flight line with a same-cycle re-allocation
    vecs[36] = '{av:1, apa:'h30, aw:3, ar:1, aid:0, default:0};
    vecs[37] = '{rr:1, ar:1, rv:1, rid:0, rpa:'h30, busy:1, default:0};
    vecs[38] = '{iv:1, ipa:'h30, av:1, apa:'h30, aw:2, ar:1, aid:1, busy:1, default:0};
    vecs[39] = '{rsv:1, rsid:0, ar:1, rv:1, rid:1, rpa:'h30, busy:1, default:0};
    vecs[40] = '{rr:1, ar:1, fv:1, fid:0, fpa:'h30, fw:3, fin:0, rv:1, rid:1, rpa:'h30, busy:1, default:0};
    vecs[41] = '{rsv:1, rsid:1, ar:1, busy:1, default:0};
    vecs[42] = '{ar:1, fv:1, fid:1, fpa:'h30, fw:2, fin:1, default:0};

    h = '{rst:1, default:0};
    apply(h);
    repeat (2) @(posedge clk_i);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk_i);
      apply(vecs[i]);
      #1 check_vec(i, vecs[i]);
    end

    // Flush in the same cycle as a request handshake
    @(negedge clk_i); h = '{av:1, apa:'h50, aw:1, default:0}; apply(h);
    #1 chk("hs_alloc_ready", alloc_ready_o, 1); chk("hs_alloc_id", alloc_id_o, 0);
    @(negedge clk_i); h = '{flush:1, rr:1, default:0}; apply(h);
    #1 chk("hs_req_valid", req_valid_o, 1);
    @(negedge clk_i); h = '{default:0}; apply(h);
    #1 chk("hs_req_after_flush", req_valid_o, 0); chk("hs_busy", busy_o, 1);
    @(negedge clk_i); h = '{rsv:1, rsid:0, default:0}; apply(h);
    @(negedge clk_i); h = '{default:0}; apply(h);
    #1 chk("hs_fill_valid", fill_valid_o, 1); chk("hs_fill_install", fill_install_o, 0);

    // Reset mid-operation, then a late response
    @(negedge clk_i); h = '{av:1, apa:'h60, default:0}; apply(h);
    @(negedge clk_i); h = '{rr:1, default:0}; apply(h);
    @(negedge clk_i); h = '{rst:1, default:0}; apply(h);
    #1 chk("rst_alloc_ready", alloc_ready_o, 0); chk("rst_req_valid", req_valid_o, 0);
    @(negedge clk_i); h = '{default:0}; apply(h);
    #1 chk("post_rst_busy", busy_o, 0); chk("post_rst_ready", alloc_ready_o, 1);
    chk("post_rst_err", err_o, 0);
    @(negedge clk_i); h = '{rsv:1, rsid:0, default:0}; apply(h);
    @(negedge clk_i); h = '{default:0}; apply(h);
    #1 chk("late_resp_err", err_o, 1); chk("late_resp_no_fill", fill_valid_o, 0);
    repeat (3) @(negedge clk_i);
    #1 chk("err_sticky", err_o, 1);
    @(negedge clk_i); h = '{rst:1, default:0}; apply(h);
    @(negedge clk_i); h = '{default:0}; apply(h);
    #1 chk("err_cleared", err_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sargantana_icache_mshr.md
# sargantana_icache_mshr

Parametrised miss-status holding register file for the Sargantana instruction cache. It is the successor to the single-outstanding ifill tracking in the icache top. Up to N_ENTRIES line misses can be in flight to the upper level at once, with optional coalescing of same-line misses, in-order issue, out-of-order responses, and handling of kill/flush and L2 invalidations. It sits between the icache controller (miss allocation, fill write-back) and the ifill request/response interface.

## Interface
Parameters:
- N_ENTRIES, 4: number of MSHR entries; power of two, ≥2; ID_W = $clog2(N_ENTRIES).
- LINE_W, 34: line-address width (physical address bits above the 6-bit line offset).
- WAY_W, 2: width of the victim-way field carried per entry.

Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  synchronous active-high reset.
- flush_i  in  1  kill all outstanding misses.
- alloc_valid_i  in  1  controller requests a miss entry.
- alloc_ready_o  out  1  allocation accepted this cycle.
- alloc_paddr_i  in  LINE_W  missing line address.
- alloc_way_i  in  WAY_W  victim way chosen by the replace unit.
- alloc_id_o  out  ID_W  entry id assigned or merged into (valid with handshake).
- alloc_merged_o  out  1  request coalesced into an existing entry.
- req_valid_o  out  1  ifill request to the upper level.
- req_ready_i  in  1  upper level accepts the request.
- req_paddr_o  out  LINE_W  line address of the request.
- req_way_o  out  WAY_W  way of the request.
- req_id_o  out  ID_W  transaction id.
- resp_valid_i  in  1  ifill response (data is routed outside the block).
- resp_id_i  in  ID_W  id of the response.
- inv_valid_i  in  1  L2 invalidation.
- inv_paddr_i  in  LINE_W  invalidated line address.
- fill_valid_o  out  1  one-cycle fill-complete pulse.
- fill_id_o / fill_paddr_o / fill_way_o  out  ID_W / LINE_W / WAY_W  completed entry fields.
- fill_install_o  out  1  1 = write tag with valid bit set; 0 = write valid bit 0 / discard.
- full_o  out  1  no FREE entry.
- busy_o  out  1  any entry not FREE.
- err_o  out  1  sticky: response to an id that is not in WAIT_RESP.

## Operation
- Per-entry state is FREE, WAIT_ISSUE or WAIT_RESP. Per-entry flags: killed, no_install. Fields: paddr, way.
- Allocation handshake: alloc_valid_i & alloc_ready_o.
  - alloc_ready_o = !rst_i & !flush_i & (merge hit | FREE entry exists & no blocked conflict).
  - A new entry takes the lowest-index FREE entry and moves to WAIT_ISSUE. Its id is pushed to an issue-order FIFO of depth N_ENTRIES.
- Issue:
  - The head of the FIFO drives req_*. req_valid_o = FIFO not empty.
  - On req_valid_o & req_ready_i: pop the FIFO and move the entry to WAIT_RESP.
  - req_* are held stable until handshake. The only exception is flush, which may drop req_valid_o.
- Response: resp_valid_i with id in WAIT_RESP.
  - The entry moves to FREE.
  - The next cycle emits fill_valid_o with the entry fields.
  - fill_install_o = !killed & !no_install.
- Invalidation: each valid entry whose paddr equals inv_paddr_i sets no_install.
- Flush:
  - WAIT_ISSUE entries go to FREE and the FIFO is cleared.
  - WAIT_RESP entries set killed. Their responses are still consumed and reported with fill_install_o=0.
- Merge candidates are entries in WAIT_ISSUE/WAIT_RESP that are not killed, not no_install, and not freeing this cycle.

## Timing
- Reset values:
  - All entries FREE and the FIFO empty.
  - All outputs 0, including alloc_ready_o during rst_i and err_o.
  - alloc_ready_o=1 from the first cycle after rst_i falls.
- Allocation to req_valid_o: 1 cycle minimum (registered state).
- Response to fill_valid_o: 1 cycle.
- A freed entry is allocatable the cycle after the response.
- Full: full_o=1 → a non-merging alloc gets alloc_ready_o=0. A merging alloc is still accepted when full.
- Simultaneous events in one cycle:
  - Alloc + response to the same line: no merge; a new entry is allocated if one is free.
  - Alloc + inv to the same line: the existing entry gets no_install; the alloc allocates new.
  - Flush + req handshake: the entry goes to WAIT_RESP killed.
  - Flush + response: fill_install_o=0.
- FIFO pointers wrap modulo N_ENTRIES; occupancy counter width is ID_W+1.
- Reset mid-operation discards all entries. Late responses after reset raise err_o.

## Configuration
- SARGANTANA_ICACHE_MSHR_COALESCE_EN defined: same-line allocs merge (alloc_merged_o=1, alloc_id_o = existing id, no new request).
- Undefined: a same-line alloc stalls (alloc_ready_o=0) until the matching entry frees. alloc_merged_o is tied to 0.

## Test plan
- Reset, alloc 0x100 way 2 → alloc_id_o=0. req_valid_o next cycle with paddr 0x100, id 0. resp id 0 → fill_valid_o=1 one cycle later with install=1.
- Four allocs 0x10–0x13 with req_ready_i=0 → full_o=1, fifth distinct alloc stalls. Issue order is ids 0,1,2,3. Responses 3,1,0,2 produce fills in that order.
- With COALESCE_EN, alloc 0x20 twice → second gets alloc_merged_o=1, same id, a single req. Without the macro, the second stalls until the fill.
- Two entries WAIT_RESP, one WAIT_ISSUE, then flush_i → WAIT_ISSUE entry freed and req_valid_o=0. Both later responses give fill_install_o=0.
- inv_paddr_i=0x30 while 0x30 is WAIT_RESP → fill_install_o=0. A new alloc of 0x30 the same cycle allocates a fresh id.
- resp_valid_i with a FREE id → err_o=1 sticky, no fill_valid_o. rst_i clears err_o.
